// File: rtl/segasys1_snd_pkg.sv
// Shared definitions for the Sega System 1 main-to-sound command path.
package segasys1_snd_pkg;

  // NMI handshake states on the sound-board side.
  typedef enum logic [1:0] {
    NMI_IDLE    = 2'd0,
    NMI_PULSE   = 2'd1,
    NMI_WAIT_RD = 2'd2,
    NMI_GAP     = 2'd3
  } nmi_state_e;

  // Default command queue depth (log2) and NMI pulse/gap length in CLK48M cycles.
  localparam int DEF_DEPTH_LOG2 = 2;
  localparam int DEF_NMI_LEN    = 96;

  // Main CPU I/O port that generates SNDRQ (decoded on the main board).
  localparam logic [4:0] SNDCMD_PORT = 5'h18;

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small synchronous command FIFO with head output, occupancy count and a
// register holding the most recently popped byte. A push into a full FIFO
// is accepted only when a pop happens on the same edge; a pop while empty
// is ignored.
module segasys1_cmdfifo
  import segasys1_snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [7:0]            last_rd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(32'd1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nx_s;
  logic [7:0]            last_rd_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;
  logic                  full_s;
  logic                  empty_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == CNT_ZERO);
  assign pop_ok_s  = pop & ~empty_s;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok_s = push & (~full_s | pop_ok_s);

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_nx_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and last-popped byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r  <= {DEPTH_LOG2{1'b0}};
      count_r   <= CNT_ZERO;
      last_rd_r <= 8'h00;
    end else begin
      count_r <= count_nx_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        last_rd_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign dout    = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_s;
  assign empty   = empty_s;
  assign last_rd = last_rd_r;

endmodule

// File: rtl/segasys1_sndcmd_rx.sv
// Sound-board receiver for main CPU sound commands: synchronises SNDRQ,
// queues one CPUDO byte per request, raises one fixed-length NMI per queued
// command and pops the head byte at the end of each sound CPU latch read.
module segasys1_sndcmd_rx
  import segasys1_snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int NMI_LEN    = DEF_NMI_LEN
) (
  input  logic                CLK48M,
  input  logic                RESETn,
  input  logic                SNDRQ,
  input  logic [7:0]          CPUDO,
  input  logic                SCPU_RD,
  output logic [7:0]          SCPU_DO,
  output logic                SNDNMI,
  output logic                SNDRDY,
  output logic [DEPTH_LOG2:0] CMDCNT,
  output logic                OVF
);

  localparam int CNT_W = (NMI_LEN > 2) ? $clog2(NMI_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             rq_s1_r;
  logic             rq_s2_r;
  logic             rd_d_r;
  logic             rq_edge_s;
  logic             pop_s;
  logic             rdy_s;
  logic             full_s;
  logic             empty_s;
  logic [7:0]       head_s;
  logic [7:0]       last_rd_s;
  logic             ovf_r;
  logic             nmi_r;
  nmi_state_e       state_r;
  nmi_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             pend_r;
  logic             pend_nx_s;

  assign rdy_s     = ~empty_s;
  assign rq_edge_s = rq_s1_r & ~rq_s2_r;
  // Falling edge of the read strobe ends the latch read and consumes the head.
  assign pop_s     = rd_d_r & ~SCPU_RD & rdy_s;

  // Two-flop SNDRQ synchroniser and read-strobe delay.
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      rq_s1_r <= 1'b0;
      rq_s2_r <= 1'b0;
      rd_d_r  <= 1'b0;
    end else begin
      rq_s1_r <= SNDRQ;
      rq_s2_r <= rq_s1_r;
      rd_d_r  <= SCPU_RD;
    end
  end

  segasys1_cmdfifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (CLK48M),
    .rst_n   (RESETn),
    .push    (rq_edge_s),
    .pop     (pop_s),
    .din     (CPUDO),
    .dout    (head_s),
    .count   (CMDCNT),
    .full    (full_s),
    .empty   (empty_s),
    .last_rd (last_rd_s)
  );

  // Sticky overflow: a request lost because the queue was full and not draining.
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      ovf_r <= 1'b0;
    end else if (rq_edge_s & full_s & ~pop_s) begin
      ovf_r <= 1'b1;
    end
  end

  // NMI sequencing: pulse, wait for the read, enforce a low gap, repeat.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pend_nx_s  = pend_r;
    case (state_r)
      NMI_IDLE: begin
        pend_nx_s = 1'b0;
        if (rdy_s) begin
          state_nx_s = NMI_PULSE;
          cnt_nx_s   = CNT_LOAD;
        end else begin
          state_nx_s = NMI_IDLE;
        end
      end
      NMI_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          pend_nx_s = 1'b0;
          // A read that already arrived during the pulse skips the wait.
          if (pend_r | pop_s) begin
            state_nx_s = NMI_GAP;
            cnt_nx_s   = CNT_LOAD;
          end else begin
            state_nx_s = NMI_WAIT_RD;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
          if (pop_s) begin
            pend_nx_s = 1'b1;
          end else begin
            pend_nx_s = pend_r;
          end
        end
      end
      NMI_WAIT_RD: begin
        if (pop_s) begin
          state_nx_s = NMI_GAP;
          cnt_nx_s   = CNT_LOAD;
        end else begin
          state_nx_s = NMI_WAIT_RD;
        end
      end
      NMI_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = NMI_IDLE;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = NMI_IDLE;
        cnt_nx_s   = CNT_ZERO;
        pend_nx_s  = 1'b0;
      end
    endcase
  end

  // NMI state, counter and registered NMI output (high exactly in PULSE).
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= NMI_IDLE;
      cnt_r   <= CNT_ZERO;
      pend_r  <= 1'b0;
      nmi_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      pend_r  <= pend_nx_s;
      nmi_r   <= (state_nx_s == NMI_PULSE);
    end
  end

  assign SCPU_DO = rdy_s ? head_s : last_rd_s;
  assign SNDNMI  = nmi_r;
  assign SNDRDY  = rdy_s;
  assign OVF     = ovf_r;

endmodule

// File: tb/tb_segasys1_sndcmd_rx.sv
// Self-checking bench for segasys1_sndcmd_rx: directed scenarios plus a
// randomized request/read phase compared against a queue-based model.
module tb_segasys1_sndcmd_rx;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;
  localparam int NMI_LEN    = 96;

  logic       CLK48M = 1'b0;
  logic       RESETn = 1'b1;
  logic       SNDRQ = 1'b0;
  logic [7:0] CPUDO = 8'h00;
  logic       SCPU_RD = 1'b0;
  logic [7:0] SCPU_DO;
  logic       SNDNMI;
  logic       SNDRDY;
  logic [2:0] CMDCNT;
  logic       OVF;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of commands, last popped byte, sticky overflow.
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ovf = 1'b0;

  // NMI waveform measurements.
  int  hi_run = 0;
  int  lo_run = 0;
  logic prev_nmi = 1'b0;
  logic seen_pulse = 1'b0;
  int  rise_cnt = 0;
  int  done_runs = 0;
  int  bad_hi_runs = 0;
  int  min_gap = 1000000;

  segasys1_sndcmd_rx #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NMI_LEN    (NMI_LEN)
  ) dut (
    .CLK48M  (CLK48M),
    .RESETn  (RESETn),
    .SNDRQ   (SNDRQ),
    .CPUDO   (CPUDO),
    .SCPU_RD (SCPU_RD),
    .SCPU_DO (SCPU_DO),
    .SNDNMI  (SNDNMI),
    .SNDRDY  (SNDRDY),
    .CMDCNT  (CMDCNT),
    .OVF     (OVF)
  );

  always #5 CLK48M = ~CLK48M;

  // Measure every NMI high run and the low gap before each new rise.
  always @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      hi_run     <= 0;
      lo_run     <= 0;
      prev_nmi   <= 1'b0;
      seen_pulse <= 1'b0;
    end else begin
      prev_nmi <= SNDNMI;
      if (SNDNMI === 1'b1) begin
        hi_run <= hi_run + 1;
        if (!prev_nmi) begin
          rise_cnt <= rise_cnt + 1;
          if (seen_pulse && lo_run < min_gap) min_gap <= lo_run;
        end
      end else begin
        lo_run <= lo_run + 1;
        if (prev_nmi) begin
          done_runs <= done_runs + 1;
          if (hi_run != NMI_LEN) bad_hi_runs <= bad_hi_runs + 1;
          hi_run     <= 0;
          lo_run     <= 1;
          seen_pulse <= 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_do();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_cnt"}, 32'(CMDCNT), 32'(mq.size()));
    chk({tag, "_rdy"}, 32'(SNDRDY), 32'(mq.size() > 0));
    chk({tag, "_ovf"}, 32'(OVF), 32'(m_ovf));
    chk({tag, "_do"},  32'(SCPU_DO), 32'(exp_do()));
  endtask

  task automatic do_reset();
    RESETn  = 1'b0;
    SNDRQ   = 1'b0;
    SCPU_RD = 1'b0;
    step();
    step();
    step();
    RESETn = 1'b1;
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    step();
  endtask

  // One main-CPU sound request; SNDRQ held 3..6 cycles, then low 2 cycles.
  task automatic send_cmd(input string tag, input logic [7:0] b);
    int hold;
    hold  = $urandom_range(3, 6);
    SNDRQ = 1'b1;
    CPUDO = b;
    step();
    step();
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
    for (int i = 2; i < hold; i++) step();
    SNDRQ = 1'b0;
    CPUDO = 8'($urandom);
    step();
    step();
    check_state(tag);
  endtask

  // One sound CPU latch read; the byte must hold while the strobe is high.
  task automatic read_cmd(input string tag);
    logic [7:0] e;
    e = exp_do();
    SCPU_RD = 1'b1;
    step();
    chk({tag, "_rd_hi0"}, 32'(SCPU_DO), 32'(e));
    step();
    chk({tag, "_rd_hi1"}, 32'(SCPU_DO), 32'(e));
    SCPU_RD = 1'b0;
    step();
    if (mq.size() > 0) m_last = mq.pop_front();
    check_state(tag);
  endtask

  task automatic wait_nmi_done(input string tag);
    int n;
    n = 0;
    while (SNDNMI !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_nmi_rise_in_time"}, 32'(n < 2000), 32'd1);
    n = 0;
    while (SNDNMI === 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_nmi_fall_in_time"}, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    #2;
    // Reset state.
    do_reset();
    chk("rst_nmi", 32'(SNDNMI), 32'd0);
    check_state("rst");
    chk("rst_do_zero", 32'(SCPU_DO), 32'h00);

    // 1: single command, exact push and NMI timing.
    SNDRQ = 1'b1;
    CPUDO = 8'h5A;
    step();
    chk("t1_rdy_edge_k", 32'(SNDRDY), 32'd0);
    step();
    mq.push_back(8'h5A);
    chk("t1_rdy_k1", 32'(SNDRDY), 32'd1);
    chk("t1_cnt_k1", 32'(CMDCNT), 32'd1);
    chk("t1_nmi_k1", 32'(SNDNMI), 32'd0);
    step();
    chk("t1_nmi_k2", 32'(SNDNMI), 32'd1);
    n = 0;
    while (SNDNMI === 1'b1 && n < 300) begin
      step();
      n++;
      if (n == 2) SNDRQ = 1'b0;
    end
    SNDRQ = 1'b0;
    chk("t1_nmi_len", 32'(n), 32'(NMI_LEN));
    chk("t1_cnt_one_push", 32'(CMDCNT), 32'd1);
    chk("t1_do", 32'(SCPU_DO), 32'h5A);

    // 2: read it back; last byte stays on the bus, no further NMI.
    base = rise_cnt;
    read_cmd("t2");
    chk("t2_do_last", 32'(SCPU_DO), 32'h5A);
    repeat (300) step();
    chk("t2_no_more_nmi", 32'(rise_cnt), 32'(base));

    // 3: four back-to-back commands, one NMI per command, pointer wrap.
    base = rise_cnt;
    for (int i = 1; i <= 4; i++) send_cmd("t3_push", 8'(i));
    chk("t3_one_nmi_during_pushes", 32'(rise_cnt), 32'(base + 1));
    for (int i = 1; i <= 4; i++) begin
      wait_nmi_done("t3");
      chk("t3_order", 32'(SCPU_DO), 32'(i));
      read_cmd("t3_pop");
    end
    repeat (300) step();
    chk("t3_nmi_per_cmd", 32'(rise_cnt), 32'(base + 4));
    chk("t3_gap_ok", 32'(min_gap >= NMI_LEN), 32'd1);

    // Randomized phase against the model.
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 2) < 2) send_cmd("rnd_push", 8'($urandom));
      else read_cmd("rnd_pop");
      repeat ($urandom_range(0, 3)) step();
    end

    // 4: overflow drops the fifth command.
    do_reset();
    for (int i = 0; i < 5; i++) send_cmd("t4_push", 8'(8'h10 + i));
    chk("t4_cnt_full", 32'(CMDCNT), 32'd4);
    chk("t4_ovf", 32'(OVF), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop_val", 32'(SCPU_DO), 32'(8'h10 + i));
      read_cmd("t4_pop");
    end
    chk("t4_empty", 32'(SNDRDY), 32'd0);
    chk("t4_ovf_sticky", 32'(OVF), 32'd1);

    // 5: full FIFO, push and pop on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++) send_cmd("t5_fill", 8'(8'hA0 + i));
    SNDRQ   = 1'b1;
    CPUDO   = 8'hA4;
    SCPU_RD = 1'b1;
    step();
    SCPU_RD = 1'b0;
    step();
    m_last = mq.pop_front();
    mq.push_back(8'hA4);
    chk("t5_cnt", 32'(CMDCNT), 32'd4);
    chk("t5_ovf", 32'(OVF), 32'd0);
    chk("t5_head", 32'(SCPU_DO), 32'hA1);
    step();
    step();
    SNDRQ = 1'b0;
    step();
    step();
    check_state("t5_after");
    for (int i = 1; i <= 4; i++) begin
      chk("t5_pop_val", 32'(SCPU_DO), 32'(8'hA0 + i));
      read_cmd("t5_pop");
    end
    chk("t5_last", 32'(SCPU_DO), 32'hA4);

    // 6: asynchronous reset in the middle of an NMI pulse.
    do_reset();
    send_cmd("t6_push", 8'h31);
    send_cmd("t6_push", 8'h32);
    chk("t6_mid_pulse", 32'(SNDNMI), 32'd1);
    #2;
    RESETn = 1'b0;
    #1;
    chk("t6_nmi", 32'(SNDNMI), 32'd0);
    chk("t6_rdy", 32'(SNDRDY), 32'd0);
    chk("t6_cnt", 32'(CMDCNT), 32'd0);
    chk("t6_ovf", 32'(OVF), 32'd0);
    chk("t6_do", 32'(SCPU_DO), 32'h00);
    step();
    step();
    RESETn = 1'b1;
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    step();
    send_cmd("t6_resume", 8'h77);
    wait_nmi_done("t6");
    read_cmd("t6_pop");
    chk("t6_resume_do", 32'(SCPU_DO), 32'h77);
    repeat (200) step();

    chk("nmi_runs_seen", 32'(done_runs > 0), 32'd1);
    chk("nmi_high_len_all", 32'(bad_hi_runs), 32'd0);
    chk("nmi_gap_all", 32'(min_gap >= NMI_LEN), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segasys1_sndcmd_rx.md
Name: segasys1_sndcmd_rx

Overview:
Sound-board end of the main-to-sound command path. It detects the main CPU's sound-request strobe (SNDRQ, an I/O write to port 0x18) and captures the command byte into a small FIFO. It then raises an NMI to the sound CPU and presents the head byte on the sound CPU read bus, popping it when the read cycle ends. It sits between the main CPU board outputs (SNDRQ/CPUDO) and the sound CPU data selector.

Parameters:
DEPTH_LOG2, 2, FIFO depth = 2^DEPTH_LOG2 commands (default 4).
NMI_LEN, 96, SNDNMI high time and minimum low gap, in CLK48M cycles.

Ports:
CLK48M  in  1  system clock; all logic on rising edge.
RESETn  in  1  asynchronous active-low reset.
SNDRQ  in  1  level strobe from main board, high for the whole I/O write (at least 3 CLK48M cycles).
CPUDO  in  8  main CPU write data; stable while SNDRQ is high.
SCPU_RD  in  1  sound CPU latch-read strobe, already address-decoded and synchronous to CLK48M.
SCPU_DO  out  8  command byte for the sound CPU.
SNDNMI  out  1  active-high NMI request to the sound CPU.
SNDRDY  out  1  high while the FIFO is non-empty.
CMDCNT  out  DEPTH_LOG2+1  number of queued commands.
OVF  out  1  sticky overflow flag.

Behaviour:
- Reset (RESETn low, asynchronous): FIFO empty, CMDCNT=0, SNDRDY=0, SNDNMI=0, OVF=0, SCPU_DO=0x00, FSM=IDLE, synchronisers cleared. A reset mid-pulse drops SNDNMI immediately.
- Request detect:
  - SNDRQ passes through two flops, s1 then s2. rq_edge = s1 & ~s2.
  - On a clock edge where rq_edge=1, CPUDO is written at the write pointer.
  - Timing: SNDRQ is first sampled high at edge k. The push happens at edge k+1, and SNDRDY/CMDCNT update after edge k+1.
  - One push per SNDRQ high period, regardless of its length.
- Full: a push while CMDCNT = 2^DEPTH_LOG2 with no simultaneous pop is dropped. FIFO contents are unchanged and OVF is set to 1 until reset.
- Pop:
  - rd_d is SCPU_RD registered. pop = rd_d & ~SCPU_RD & SNDRDY, i.e. the falling edge of the read strobe.
  - On pop: the read pointer advances, CMDCNT decrements, and the popped byte is loaded into last_rd.
  - A pop while empty is ignored.
- Simultaneous push and pop: both take effect and CMDCNT is unchanged. When full, the push is accepted and no overflow is flagged. When empty, only the push takes effect.
- SCPU_DO: the FIFO head byte while SNDRDY=1, otherwise last_rd. It is stable for the whole SCPU_RD high period.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. CMDCNT ranges from 0 to 2^DEPTH_LOG2.
- NMI FSM (state register; SNDNMI is registered, high only in PULSE):
  - IDLE: if SNDRDY=1, go to PULSE and load the counter with NMI_LEN-1.
  - PULSE: SNDNMI=1 and the counter decrements. At 0, go to WAIT_RD.
  - WAIT_RD: SNDNMI=0. On pop, go to GAP and load the counter with NMI_LEN-1.
  - GAP: SNDNMI=0 and the counter decrements. At 0, go to IDLE.
  - A pop during PULSE is remembered: PULSE then goes straight to GAP at the end of its count.
  - Net effect: one NMI per queued command. SNDNMI rises at edge k+2 of the first push and stays high exactly NMI_LEN cycles. Successive NMIs are separated by at least NMI_LEN low cycles.
- Counter width is ceil(log2(NMI_LEN)) bits. NMI_LEN must be 2 or more.

Decomposition:
- Shared package segasys1_snd_pkg holds:
  - FSM state encoding: IDLE, PULSE, WAIT_RD, GAP.
  - Default DEPTH_LOG2 and NMI_LEN constants.
  - SNDCMD_PORT = 5'h18 for the main-side decode.
- One sub-module: segasys1_cmdfifo. It is a synchronous FIFO with push, pop, din, dout (head), count, full, empty and last-popped register, and implements the simultaneous push/pop rules.
- The top level holds the synchronisers, edge detectors, overflow flag and NMI FSM.

Test Plan:
1. Reset, then SNDRQ high 4 cycles with CPUDO=0x5A → push at edge k+1, SNDRDY=1, CMDCNT=1. SNDNMI high from k+2 for 96 cycles. SCPU_DO=0x5A.
2. Pulse SCPU_RD 1→0 after the NMI → CMDCNT=0, SNDRDY=0, SCPU_DO stays 0x5A (last_rd). No further NMI.
3. Push 0x01..0x04 back-to-back (SNDRQ low at least 2 cycles between) → exactly one NMI. After each pop, the next NMI starts no earlier than 96 low cycles later. SCPU_DO reads 0x01,0x02,0x03,0x04 in order, covering pointer wrap.
4. Push 0x10..0x14 (5 commands) with no reads → CMDCNT=4, OVF=1, 0x14 dropped. Pops return 0x10..0x13.
5. With the FIFO full (0xA0..0xA3), align the SNDRQ push edge with the SCPU_RD falling edge using CPUDO=0xA4 → CMDCNT stays 4, OVF stays 0. Later pops yield 0xA1..0xA4.
6. Assert RESETn low mid-PULSE with 2 entries queued → SNDNMI, SNDRDY, CMDCNT and OVF all 0 immediately (asynchronous). SCPU_DO=0x00. Normal operation resumes after release.
